uart_rx_fifo: RTL

Receive-side byte buffer between the UART receiver and the CPU I/O bus. It captures each byte the UART strobes out into a 16-entry FIFO, so the CPU can drain bursts at its own pace. It exposes a two-register read port (data and status) with a sticky overflow flag. A CPU-side read of the data register pops one byte.

---
 rtl/uart_rx_fifo_pkg.sv | 19 +
 rtl/sync_fifo_mem.sv | 29 ++
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO slice.
// Data width, status bit indices, register addresses.
package uart_rx_fifo_pkg;

`ifndef UartDataWidth
`define UartDataWidth 8
`endif

  localparam int UART_DW = `UartDataWidth;

  localparam int ST_AVAIL = 0;
  localparam int ST_HALF  = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, sync write, comb read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
import uart_rx_fifo_pkg::*;

module sync_fifo_mem #(
  parameter int DATA_W = UART_DW,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with a data/status CPU read port.
// Ports: clk, rst (sync, active-low), rx_data/rx_strobe push,
// io_rd/io_addr read, io_dout registered data, rx_avail.
import uart_rx_fifo_pkg::*;

module uart_rx_fifo #(
  parameter int DATA_W = UART_DW,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_strobe,
  input  logic              io_rd,
  input  logic              io_addr,
  output logic [DATA_W-1:0] io_dout,
  output logic              rx_avail
);

  localparam logic [ADDR_W:0] CNT_FULL =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_HALF =
    (ADDR_W+1)'(DEPTH / 2);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] status;

  logic full;
  logic empty;
  logic half;
  logic rd_dat;
  logic rd_st;
  logic pop;
  logic push;
  logic drop;
  logic mem_we;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign half  = (count >= CNT_HALF);

  assign rd_dat = io_rd && (io_addr == ADDR_DATA);
  assign rd_st  = io_rd && (io_addr == ADDR_STATUS);

  // A same-cycle pop frees a slot, so a push
  // into a full FIFO is only dropped without one.
  assign pop  = rd_dat && !empty;
  assign push = rx_strobe && (!full || pop);
  assign drop = rx_strobe && full && !pop;

  assign mem_we = push && rst;

  always_comb begin
    status           = '0;
    status[ST_AVAIL] = !empty;
    status[ST_HALF]  = half;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf;
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      dout_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Overflow on this edge wins over the
      // clear-on-status-read.
      if (drop) begin
        ovf <= 1'b1;
      end else if (rd_st) begin
        ovf <= 1'b0;
      end

      unique case (1'b1)
        rd_dat:  dout_q <= pop ? rd_word : '0;
        rd_st:   dout_q <= status;
        default: dout_q <= dout_q;
      endcase
    end
  end

  assign io_dout  = dout_q;
  assign rx_avail = !empty;

endmodule
